uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 46 ++++
 rtl/uart_rx_core.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - per-bit counter with mid-bit sample strobes and bit-end strobe
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic clr,
    output logic samp_pre,
    output logic samp_mid,
    output logic samp_post,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_PRE  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(H);
    localparam logic [CW-1:0] CNT_POST = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        bit_end   = (cnt_q == CNT_LAST);
        samp_pre  = (cnt_q == CNT_PRE);
        samp_mid  = (cnt_q == CNT_MID);
        samp_post = (cnt_q == CNT_POST);
        cnt_d     = cnt_q + 1'b1;
        if (clr || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: synchroniser, frame FSM, shift and error checks
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_en_sig,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done_sig,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [3:0] IDX_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] IDX_STOP_LAST = 4'(STOP_BITS - 1);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic rx_s, rx_fall;

    rx_state_e state_q, state_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 samp0_q, samp0_d;
    logic                 samp1_q, samp1_d;
    logic                 par_pend_q, par_pend_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 done_q, done_d;

    logic cnt_clr;
    logic samp_pre, samp_mid, samp_post, bit_end;
    logic maj;
    logic par_x;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .samp_pre (samp_pre),
        .samp_mid (samp_mid),
        .samp_post(samp_post),
        .bit_end  (bit_end)
    );

    assign rx_s    = sync2_q;
    assign rx_fall = sync3_q & ~sync2_q;

    always_comb begin
        sync1_d      = rx;
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_pend_d   = par_pend_q;
        stop_err_d   = stop_err_q;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        done_d       = 1'b0;
        par_x        = 1'b0;
        // Counter sits at zero in IDLE so every frame starts counting from the start edge.
        cnt_clr      = (state_q == ST_IDLE);
        samp0_d      = samp_pre ? rx_s : samp0_q;
        samp1_d      = samp_mid ? rx_s : samp1_q;
        maj          = majority3(samp0_q, samp1_q, rx_s);

        case (state_q)
            ST_IDLE: begin
                if (rx_fall && rx_en_sig) begin
                    state_d    = ST_START;
                    bit_idx_d  = '0;
                    par_pend_d = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (samp_post && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (samp_post) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_idx_q == IDX_DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (samp_post) begin
                    par_x      = (^shift_q) ^ maj;
                    par_pend_d = (PARITY == PAR_ODD) ? ~par_x : par_x;
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (samp_post) begin
                    if (!maj) begin
                        stop_err_d = 1'b1;
                    end
                    // Commit at mid-bit so a following start edge is never missed.
                    if (bit_idx_q == IDX_STOP_LAST) begin
                        rx_data_d    = shift_q;
                        parity_err_d = (PARITY != PAR_NONE) && par_pend_q;
                        frame_err_d  = stop_err_q | ~maj;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end else if (bit_end) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            sync3_q      <= 1'b1;
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            samp0_q      <= 1'b1;
            samp1_q      <= 1'b1;
            par_pend_q   <= 1'b0;
            stop_err_q   <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            samp0_q      <= samp0_d;
            samp1_q      <= samp1_d;
            par_pend_q   <= par_pend_d;
            stop_err_q   <= stop_err_d;
            rx_data_q    <= rx_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            done_q       <= done_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_done_sig = done_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;

    logic       sysclk;
    logic       rst_n;
    logic       rx_en;
    logic       rx_a, rx_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_done_a, rx_done_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       busy_a, busy_b;

    int         total = 0;
    int         bad   = 0;
    int         done_a = 0;
    int         done_b = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] prev_a = 8'h00;

    uart_rx_core #(
        .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .rx(rx_a), .rx_en_sig(rx_en),
        .rx_data(rx_data_a), .rx_done_sig(rx_done_a), .parity_err(perr_a),
        .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx_core #(
        .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .rx(rx_b), .rx_en_sig(rx_en),
        .rx_data(rx_data_b), .rx_done_sig(rx_done_b), .parity_err(perr_b),
        .frame_err(ferr_b), .busy(busy_b)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (rx_done_a) begin
            done_a <= done_a + 1;
            prev_a <= last_a;
            last_a <= rx_data_a;
        end
        if (rx_done_b) begin
            done_b <= done_b + 1;
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        repeat (16) step();
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_en) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rx_en = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        total++; if (rx_data_a !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", rx_data_a); end
        total++; if (rx_done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", rx_done_a); end
        total++; if (perr_a !== 1'b0) begin bad++; $display("FAIL reset_perr: got %0b want 0", perr_a); end
        total++; if (ferr_a !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %0b want 0", ferr_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b: got %0b want 0", busy_b); end
    endtask

    task automatic test_basic();
        int         d0;
        int         lat;
        logic [7:0] d;
        d0  = done_a;
        lat = 0;
        d   = 8'hA5;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(0, d[i]);
        rx_a = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (rx_done_a && lat == 0) lat = n;
        end
        total++; if (lat !== 13) begin bad++; $display("FAIL basic_latency: got %0d want 13", lat); end
        total++; if (done_a - d0 !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_a - d0); end
        total++; if (rx_data_a !== 8'hA5) begin bad++; $display("FAIL basic_data: got %0h want a5", rx_data_a); end
        total++; if (perr_a !== 1'b0) begin bad++; $display("FAIL basic_perr: got %0b want 0", perr_a); end
        total++; if (ferr_a !== 1'b0) begin bad++; $display("FAIL basic_ferr: got %0b want 0", ferr_a); end
    endtask

    task automatic test_parity();
        int d0;
        d0 = done_b;
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        drive_bit(1, 1'b1);
        total++; if (done_b - d0 !== 1) begin bad++; $display("FAIL par_done1: got %0d want 1", done_b - d0); end
        total++; if (perr_b !== 1'b1) begin bad++; $display("FAIL par_err_set: got %0b want 1", perr_b); end
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        drive_bit(1, 1'b1);
        total++; if (done_b - d0 !== 2) begin bad++; $display("FAIL par_done2: got %0d want 2", done_b - d0); end
        total++; if (perr_b !== 1'b0) begin bad++; $display("FAIL par_err_clr: got %0b want 0", perr_b); end
        total++; if (rx_data_b !== 8'h03) begin bad++; $display("FAIL par_data: got %0h want 03", rx_data_b); end
        total++; if (ferr_b !== 1'b0) begin bad++; $display("FAIL par_ferr: got %0b want 0", ferr_b); end
    endtask

    task automatic test_glitch();
        int d0;
        int busy_hi;
        d0      = done_a;
        busy_hi = 0;
        rx_a    = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            step();
            if (busy_a) busy_hi++;
            if (n == 2) rx_a = 1'b1;
        end
        total++; if (busy_hi !== 10) begin bad++; $display("FAIL glitch_busy_cycles: got %0d want 10", busy_hi); end
        total++; if (done_a - d0 !== 0) begin bad++; $display("FAIL glitch_no_done: got %0d want 0", done_a - d0); end
        drive_bit(0, 1'b1);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        total++; if (done_a - d0 !== 1) begin bad++; $display("FAIL glitch_next_done: got %0d want 1", done_a - d0); end
        total++; if (rx_data_a !== 8'h5A) begin bad++; $display("FAIL glitch_next_data: got %0h want 5a", rx_data_a); end
    endtask

    task automatic test_break();
        int d0;
        d0 = done_a;
        repeat (40) drive_bit(0, 1'b0);
        total++; if (done_a - d0 !== 1) begin bad++; $display("FAIL break_done_count: got %0d want 1", done_a - d0); end
        total++; if (ferr_a !== 1'b1) begin bad++; $display("FAIL break_ferr: got %0b want 1", ferr_a); end
        total++; if (rx_data_a !== 8'h00) begin bad++; $display("FAIL break_data: got %0h want 00", rx_data_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL break_busy: got %0b want 0", busy_a); end
        repeat (2) drive_bit(0, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        total++; if (done_a - d0 !== 2) begin bad++; $display("FAIL break_next_done: got %0d want 2", done_a - d0); end
        total++; if (rx_data_a !== 8'h3C) begin bad++; $display("FAIL break_next_data: got %0h want 3c", rx_data_a); end
        total++; if (ferr_a !== 1'b0) begin bad++; $display("FAIL break_next_ferr: got %0b want 0", ferr_a); end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_a;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        rx_a  = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %0b want 0", busy_a); end
        total++; if (rx_data_a !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %0h want 00", rx_data_a); end
        repeat (2) drive_bit(0, 1'b1);
        total++; if (done_a - d0 !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_a - d0); end
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        total++; if (done_a - d0 !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", done_a - d0); end
        total++; if (prev_a !== 8'h11) begin bad++; $display("FAIL b2b_first: got %0h want 11", prev_a); end
        total++; if (last_a !== 8'h22) begin bad++; $display("FAIL b2b_second: got %0h want 22", last_a); end
    endtask

    task automatic test_enable();
        int d0;
        d0    = done_a;
        rx_en = 1'b0;
        send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        total++; if (done_a - d0 !== 0) begin bad++; $display("FAIL en_off_done: got %0d want 0", done_a - d0); end
        total++; if (rx_data_a !== 8'h22) begin bad++; $display("FAIL en_off_data: got %0h want 22", rx_data_a); end
        rx_en = 1'b1;
        drive_bit(0, 1'b0);
        rx_en = 1'b0;
        for (int i = 0; i < 8; i++) drive_bit(0, (i == 1 || i == 2 || i == 5 || i == 6) ? 1'b1 : 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        rx_en = 1'b1;
        total++; if (done_a - d0 !== 1) begin bad++; $display("FAIL en_mid_done: got %0d want 1", done_a - d0); end
        total++; if (rx_data_a !== 8'h66) begin bad++; $display("FAIL en_mid_data: got %0h want 66", rx_data_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_reset_mid();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
